// File: rtl/alu_pkg.sv
// Shared definitions for the ASCII command parser that feeds the 8-bit ALU:
// operator codes, character constants, parser state encoding and helpers.
package alu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h2B;
  localparam logic [7:0] OP_SUB   = 8'h2D;
  localparam logic [7:0] OP_MUL   = 8'h2A;
  localparam logic [7:0] OP_DIV   = 8'h2F;
  localparam logic [7:0] OP_AND   = 8'h26;
  localparam logic [7:0] OP_OR    = 8'h7C;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    S_A_START,
    S_A_NEG,
    S_A_DIG,
    S_B_START,
    S_B_NEG,
    S_B_DIG,
    S_ISSUE,
    S_ERROR
  } parser_state_e;

  function automatic logic is_operator(input logic [7:0] ch);
    return (ch == OP_ADD) || (ch == OP_SUB) || (ch == OP_MUL) ||
           (ch == OP_DIV) || (ch == OP_AND) || (ch == OP_OR);
  endfunction

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_ZERO) && (ch <= CH_NINE);
  endfunction

endpackage

// File: rtl/alu_cmd_parser_dec_accumulator.sv
// Decimal magnitude accumulator shared by both operands; flags values that
// would leave the signed 8-bit range (127 positive, 128 negative).
module dec_accumulator (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       load,
  input  logic       step,
  input  logic       clear,
  input  logic       sign,
  output logic [7:0] magnitude,
  output logic       range_err
);

  logic [9:0]  acc;
  logic [10:0] acc_next;
  logic [10:0] limit;

  // range_err is not gated by step so the parser's step decision never loops back through it
  always_comb begin
    acc_next  = 11'(acc) * 11'd10 + {7'd0, digit};
    limit     = sign ? 11'd128 : 11'd127;
    range_err = (acc_next > limit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= {6'd0, digit};
    end else if (step && !range_err) begin
      acc <= acc_next[9:0];
    end
  end

  assign magnitude = acc[7:0];

endmodule

// File: rtl/alu_cmd_parser.sv
// ASCII command parser "<A><op><B>=" presenting operands/operator to the ALU.
// Define ALU_CMD_PARSER_DIVZERO_EN to reject division by zero as a parse error.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR   = 8'h3D,
  parameter logic [7:0] ABORT_CHAR  = 8'h1B,
  parameter logic [7:0] RESYNC_CHAR = 8'h0A
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] data_a,
  output logic [7:0] data_b,
  output logic [7:0] operation,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       parse_error
);

  parser_state_e state, state_next;
  logic          accept;
  logic          sign;
  logic          acc_load, acc_step, acc_clear, sign_set;
  logic          lat_a, lat_b, err_set;
  logic [7:0]    magnitude;
  logic          range_err;
  logic [7:0]    signed_val;

  assign rx_ready   = (state != S_ISSUE);
  assign cmd_valid  = (state == S_ISSUE);
  assign accept     = rx_valid && rx_ready;
  assign signed_val = sign ? (~magnitude + 8'd1) : magnitude;

  dec_accumulator u_acc (
    .clock     (clock),
    .reset     (reset),
    .digit     (rx_data[3:0]),
    .load      (acc_load),
    .step      (acc_step),
    .clear     (acc_clear),
    .sign      (sign),
    .magnitude (magnitude),
    .range_err (range_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_A_START;
      sign        <= 1'b0;
      data_a      <= '0;
      data_b      <= '0;
      operation   <= '0;
      parse_error <= 1'b0;
    end else begin
      state       <= state_next;
      parse_error <= err_set;
      if (acc_clear)     sign <= 1'b0;
      else if (sign_set) sign <= 1'b1;
      if (lat_a) begin
        data_a    <= signed_val;
        operation <= rx_data;
      end
      if (lat_b) data_b <= signed_val;
    end
  end

  always_comb begin
    state_next = state;
    acc_load   = 1'b0;
    acc_step   = 1'b0;
    acc_clear  = 1'b0;
    sign_set   = 1'b0;
    lat_a      = 1'b0;
    lat_b      = 1'b0;
    err_set    = 1'b0;
    if (state == S_ISSUE) begin
      if (cmd_ready) state_next = S_A_START;
    end else if (accept) begin
      if (rx_data == ABORT_CHAR) begin
        state_next = S_A_START;
        acc_clear  = 1'b1;
      end else if (state == S_ERROR) begin
        if ((rx_data == TERM_CHAR) || (rx_data == RESYNC_CHAR)) state_next = S_A_START;
      end else if (rx_data != CH_SPACE) begin
        case (state)
          S_A_START, S_B_START: begin
            if (is_digit(rx_data)) begin
              acc_load = 1'b1;
              if (state == S_A_START) state_next = S_A_DIG;
              else                    state_next = S_B_DIG;
            end else if (rx_data == CH_MINUS) begin
              sign_set = 1'b1;
              if (state == S_A_START) state_next = S_A_NEG;
              else                    state_next = S_B_NEG;
            end else begin
              state_next = S_ERROR;
            end
          end
          S_A_NEG, S_B_NEG: begin
            if (is_digit(rx_data)) begin
              acc_load = 1'b1;
              if (state == S_A_NEG) state_next = S_A_DIG;
              else                  state_next = S_B_DIG;
            end else begin
              state_next = S_ERROR;
            end
          end
          S_A_DIG: begin
            if (is_digit(rx_data)) begin
              acc_step = 1'b1;
              if (range_err) state_next = S_ERROR;
            end else if (is_operator(rx_data)) begin
              lat_a      = 1'b1;
              acc_clear  = 1'b1;
              state_next = S_B_START;
            end else begin
              state_next = S_ERROR;
            end
          end
          S_B_DIG: begin
            if (is_digit(rx_data)) begin
              acc_step = 1'b1;
              if (range_err) state_next = S_ERROR;
            end else if (rx_data == TERM_CHAR) begin
`ifdef ALU_CMD_PARSER_DIVZERO_EN
              if ((operation == OP_DIV) && (magnitude == '0)) begin
                state_next = S_ERROR;
              end else begin
                lat_b      = 1'b1;
                acc_clear  = 1'b1;
                state_next = S_ISSUE;
              end
`else
              lat_b      = 1'b1;
              acc_clear  = 1'b1;
              state_next = S_ISSUE;
`endif
            end else begin
              state_next = S_ERROR;
            end
          end
          default: state_next = S_ERROR;
        endcase
      end
      // Entering the error state abandons the partial operand and raises the pulse once
      if ((state_next == S_ERROR) && (state != S_ERROR)) begin
        err_set   = 1'b1;
        acc_clear = 1'b1;
      end
    end
  end

endmodule
